jtag_tap_core: RTL
==================

Name: jtag_tap_core

Overview:
- Parametrised IEEE 1149.1-style test access port. Contains:
  - 16-state TAP controller
  - instruction register (IR) of configurable width
  - bypass, IDCODE, optional USERCODE and boundary-scan (BSR) data registers
  - TDO multiplexer
- Successor to the fixed 4-bit-IR, 10-cell TAP: opcodes, BSR length and ID values are parameters.
- Adds TRST_N, falling-edge TDO with TDO_EN, and a registered update stage for the BSR.
- Sits between the board JTAG header and the core/IO boundary-scan cells.

Parameters:
- IR_WIDTH, 4, instruction register width (>=2)
- BSR_LEN, 10, number of boundary-scan cells (>=1)
- IDCODE_VAL, 32'h1000_0A5B, device ID; bit 0 must be 1
- USERCODE_VAL, 32'hCAFE_0001, user code value
- OP_IDCODE, 4'h7; OP_BYPASS, 4'hF; OP_SAMPLE, 4'h1; OP_EXTEST, 4'h2; OP_INTEST, 4'h3; OP_USERCODE, 4'h8. Each is IR_WIDTH bits wide.

Ports:
- TCK  in  1  test clock; the only clock. State, IR and DR logic on posedge; TDO on negedge.
- TRST_N  in  1  asynchronous active-low reset
- TMS  in  1  mode select, sampled on posedge TCK
- TDI  in  1  serial data in
- TDO  out  1  serial data out
- TDO_EN  out  1  1 while TDO carries valid shift data
- STATE  out  4  current TAP state code
- TLR  out  1  1 while in Test-Logic-Reset
- IR_OUT  out  IR_WIDTH  latched (active) instruction
- BSR_IN  in  BSR_LEN  parallel capture values from pins/core
- BSR_OUT  out  BSR_LEN  updated boundary-scan values
- BYPASS_SEL, IDCODE_SEL, USERCODE_SEL, SAMPLE_SEL, EXTEST_SEL, INTEST_SEL  out  1 each  decoded one-hot instruction selects

Behaviour:
- State codes:
  - TLR=F, RTI=C
  - DR path: SELDR=7, CAPDR=6, SHDR=2, EX1DR=1, PAUSEDR=3, EX2DR=0, UPDR=5
  - IR path: SELIR=4, CAPIR=E, SHIR=A, EX1IR=9, PAUSEIR=B, EX2IR=8, UPIR=D
- Transitions follow the standard TMS graph, one per posedge. Five consecutive TMS=1 reach TLR from any state.
- TRST_N low, asynchronously:
  - STATE=TLR, IR_OUT=OP_IDCODE
  - IR shift register 0, all DR shift registers 0, BSR_OUT=0
  - TDO=0, TDO_EN=0
- Posedge in TLR (synchronous reset): IR_OUT<=OP_IDCODE. BSR_OUT is held, not cleared.
- Decode:
  - IR_OUT equal to a defined opcode asserts exactly one *_SEL.
  - Any undefined opcode asserts BYPASS_SEL.
  - Exactly one select is high at all times.
- Capture (posedge while in CAP state):
  - IR shift register <= {0..0, 2'b01}.
  - Selected DR loads:
    - bypass <= 0
    - IDCODE register <= IDCODE_VAL
    - USERCODE register <= USERCODE_VAL
    - BSR shift register <= BSR_IN (SAMPLE/EXTEST/INTEST)
- Shift (posedge while in SH state): selected register shifts right. TDI enters the MSB; the LSB leaves first. PAUSE and EXIT states hold the contents.
- Update (posedge while in UP state):
  - UPIR: IR_OUT <= IR shift register.
  - UPDR with SAMPLE, EXTEST or INTEST selected: BSR_OUT <= BSR shift register.
  - UPDR with any other instruction: no effect.
- TDO (negedge TCK):
  - In SHDR: TDO <= LSB of the selected DR, TDO_EN <= 1.
  - In SHIR: TDO <= IR shift register LSB, TDO_EN <= 1.
  - Elsewhere: TDO <= 0, TDO_EN <= 0.
- Latency: first TDI bit reappears at TDO after:
  - bypass: 1 shift cycle
  - IDCODE/USERCODE: 32 shift cycles
  - BSR: BSR_LEN shift cycles
- IR_OUT changes only in UPIR, TLR or on reset. An instruction switch mid-DR-scan is impossible by construction.
- TRST_N asserted mid-shift aborts the scan. No partial update reaches IR_OUT or BSR_OUT.

Optional Feature:
- Macro: JTAG_TAP_USERCODE_EN.
- Defined: the USERCODE register is present and OP_USERCODE selects it.
- Undefined: the register is removed, OP_USERCODE decodes as an undefined opcode (BYPASS_SEL=1), and USERCODE_SEL is tied to 0.

Test Plan:
- Reset:
  - TRST_N=0 mid-SHDR -> STATE=F, IR_OUT=4'h7, IDCODE_SEL=1, TDO=0, TDO_EN=0.
  - Then TMS=0 for one cycle -> STATE=C.
- TMS=1 reset from any state:
  - From PAUSEIR, apply 5 cycles TMS=1 -> STATE=F.
  - From any other of the 16 states, 5 cycles TMS=1 -> STATE=F every time.
- IDCODE: after reset, walk to SHDR and shift 32 bits -> TDO stream LSB-first equals 32'h1000_0A5B, bit0=1 first, TDO_EN=1 throughout.
- IR scan:
  - Shift 4'h2 into the IR -> TDO returns the capture pattern 4'b0001 LSB-first.
  - After UPIR -> IR_OUT=4'h2, EXTEST_SEL=1.
  - Repeat with 4'h5 -> BYPASS_SEL=1.
- Bypass: with IR=4'hF, shift 8 bits 8'hA5 -> TDO shows a 0 then A5 delayed by one cycle; BSR_OUT unchanged.
- BSR with BSR_LEN=10 and IR=SAMPLE:
  - BSR_IN=10'h2AA, then CAPDR and 10 shifts with TDI pattern 10'h155 -> TDO yields 10'h2AA.
  - After UPDR -> BSR_OUT=10'h155.
  - Repeat with IR=IDCODE -> BSR_OUT holds 10'h155.

Source files
------------

// File: rtl/jtag_tap_core_if.sv
// Board-side JTAG signals plus the parallel boundary-scan and instruction-select
// bundle of jtag_tap_core. The TAP itself takes the slave modport.
interface jtag_tap_core_if #(
  parameter int IR_WIDTH = 4,
  parameter int BSR_LEN  = 10
);
  logic                TMS;
  logic                TDI;
  logic                TDO;
  logic                TDO_EN;
  logic [3:0]          STATE;
  logic                TLR;
  logic [IR_WIDTH-1:0] IR_OUT;
  logic [BSR_LEN-1:0]  BSR_IN;
  logic [BSR_LEN-1:0]  BSR_OUT;
  logic                BYPASS_SEL;
  logic                IDCODE_SEL;
  logic                USERCODE_SEL;
  logic                SAMPLE_SEL;
  logic                EXTEST_SEL;
  logic                INTEST_SEL;

  modport slave (
    input  TMS, TDI, BSR_IN,
    output TDO, TDO_EN, STATE, TLR, IR_OUT, BSR_OUT,
           BYPASS_SEL, IDCODE_SEL, USERCODE_SEL, SAMPLE_SEL, EXTEST_SEL, INTEST_SEL
  );

  modport master (
    output TMS, TDI, BSR_IN,
    input  TDO, TDO_EN, STATE, TLR, IR_OUT, BSR_OUT,
           BYPASS_SEL, IDCODE_SEL, USERCODE_SEL, SAMPLE_SEL, EXTEST_SEL, INTEST_SEL
  );
endinterface

// File: rtl/jtag_tap_core.sv
// IEEE 1149.1-style TAP: 16-state controller, IR, bypass/IDCODE/BSR data registers.
// Define JTAG_TAP_USERCODE_EN to include the USERCODE register.
//
// state   | code | meaning
// TLR     | F    | test-logic-reset, IR forced to IDCODE
// RTI     | C    | run-test/idle
// SELDR   | 7    | select DR scan
// CAPDR   | 6    | parallel load of selected DR
// SHDR    | 2    | shift selected DR, TDI -> MSB, LSB -> TDO
// EX1DR   | 1    | exit-1 DR
// PAUSEDR | 3    | pause DR, contents held
// EX2DR   | 0    | exit-2 DR
// UPDR    | 5    | BSR update stage loads
// SELIR   | 4    | select IR scan
// CAPIR   | E    | IR shift register loads 0..01
// SHIR    | A    | shift IR
// EX1IR   | 9    | exit-1 IR
// PAUSEIR | B    | pause IR
// EX2IR   | 8    | exit-2 IR
// UPIR    | D    | active instruction loads from IR shift register
module jtag_tap_core #(
  parameter int                  IR_WIDTH     = 4,
  parameter int                  BSR_LEN      = 10,
  parameter logic [31:0]         IDCODE_VAL   = 32'h1000_0A5B,
  parameter logic [31:0]         USERCODE_VAL = 32'hCAFE_0001,
  parameter logic [IR_WIDTH-1:0] OP_IDCODE    = IR_WIDTH'(4'h7),
  parameter logic [IR_WIDTH-1:0] OP_BYPASS    = IR_WIDTH'(4'hF),
  parameter logic [IR_WIDTH-1:0] OP_SAMPLE    = IR_WIDTH'(4'h1),
  parameter logic [IR_WIDTH-1:0] OP_EXTEST    = IR_WIDTH'(4'h2),
  parameter logic [IR_WIDTH-1:0] OP_INTEST    = IR_WIDTH'(4'h3),
  parameter logic [IR_WIDTH-1:0] OP_USERCODE  = IR_WIDTH'(4'h8)
) (
  input  logic            TCK,
  input  logic            TRST_N,
  jtag_tap_core_if.slave  tap
);

  typedef enum logic [3:0] {
    S_EX2DR   = 4'h0,
    S_EX1DR   = 4'h1,
    S_SHDR    = 4'h2,
    S_PAUSEDR = 4'h3,
    S_SELIR   = 4'h4,
    S_UPDR    = 4'h5,
    S_CAPDR   = 4'h6,
    S_SELDR   = 4'h7,
    S_EX2IR   = 4'h8,
    S_EX1IR   = 4'h9,
    S_SHIR    = 4'hA,
    S_PAUSEIR = 4'hB,
    S_RTI     = 4'hC,
    S_UPIR    = 4'hD,
    S_CAPIR   = 4'hE,
    S_TLR     = 4'hF
  } tap_state_e;

  typedef struct packed {
    logic bypass;
    logic idcode;
    logic usercode;
    logic sample;
    logic extest;
    logic intest;
  } sel_t;

  function automatic tap_state_e next_state(input tap_state_e s, input logic tms);
    tap_state_e n;
    case (s)
      S_TLR:     n = tms ? S_TLR   : S_RTI;
      S_RTI:     n = tms ? S_SELDR : S_RTI;
      S_SELDR:   n = tms ? S_SELIR : S_CAPDR;
      S_CAPDR:   n = tms ? S_EX1DR : S_SHDR;
      S_SHDR:    n = tms ? S_EX1DR : S_SHDR;
      S_EX1DR:   n = tms ? S_UPDR  : S_PAUSEDR;
      S_PAUSEDR: n = tms ? S_EX2DR : S_PAUSEDR;
      S_EX2DR:   n = tms ? S_UPDR  : S_SHDR;
      S_UPDR:    n = tms ? S_SELDR : S_RTI;
      S_SELIR:   n = tms ? S_TLR   : S_CAPIR;
      S_CAPIR:   n = tms ? S_EX1IR : S_SHIR;
      S_SHIR:    n = tms ? S_EX1IR : S_SHIR;
      S_EX1IR:   n = tms ? S_UPIR  : S_PAUSEIR;
      S_PAUSEIR: n = tms ? S_EX2IR : S_PAUSEIR;
      S_EX2IR:   n = tms ? S_UPIR  : S_SHIR;
      S_UPIR:    n = tms ? S_SELDR : S_RTI;
      default:   n = S_TLR;
    endcase
    return n;
  endfunction

  // Priority chain keeps the selects one-hot even if two opcode parameters collide.
  function automatic sel_t decode(input logic [IR_WIDTH-1:0] ir);
    sel_t s;
    s = '0;
    if (ir == OP_IDCODE)        s.idcode = 1'b1;
    else if (ir == OP_BYPASS)   s.bypass = 1'b1;
    else if (ir == OP_SAMPLE)   s.sample = 1'b1;
    else if (ir == OP_EXTEST)   s.extest = 1'b1;
    else if (ir == OP_INTEST)   s.intest = 1'b1;
`ifdef JTAG_TAP_USERCODE_EN
    else if (ir == OP_USERCODE) s.usercode = 1'b1;
`else
    else if (ir == OP_USERCODE) s.bypass = 1'b1;
`endif
    else                        s.bypass = 1'b1;
    return s;
  endfunction

  tap_state_e          r_state;
  logic                r_tlr;
  tap_state_e          w_next_state;
  logic [IR_WIDTH-1:0] r_ir_sr;
  logic [IR_WIDTH-1:0] r_ir_out;
  sel_t                r_sel;
  logic                r_bypass;
  logic [31:0]         r_idcode;
`ifdef JTAG_TAP_USERCODE_EN
  logic [31:0]         r_usercode;
`endif
  logic [BSR_LEN-1:0]  r_bsr_sr;
  logic [BSR_LEN-1:0]  r_bsr_out;
  logic [BSR_LEN:0]    w_bsr_cat;
  logic                w_bsr_sel;
  logic                w_dr_lsb;
  logic                r_tdo;
  logic                r_tdo_en;

  assign w_next_state = next_state(r_state, tap.TMS);

  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      r_state <= S_TLR;
      r_tlr   <= 1'b1;
    end else begin
      r_state <= w_next_state;
      r_tlr   <= (w_next_state == S_TLR);
    end
  end

  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      r_ir_sr  <= '0;
      r_ir_out <= OP_IDCODE;
      r_sel    <= decode(OP_IDCODE);
    end else begin
      case (r_state)
        S_TLR: begin
          r_ir_out <= OP_IDCODE;
          r_sel    <= decode(OP_IDCODE);
        end
        S_CAPIR: r_ir_sr <= IR_WIDTH'(2'b01);
        S_SHIR:  r_ir_sr <= {tap.TDI, r_ir_sr[IR_WIDTH-1:1]};
        S_UPIR: begin
          r_ir_out <= r_ir_sr;
          r_sel    <= decode(r_ir_sr);
        end
        default: ;
      endcase
    end
  end

  assign w_bsr_sel = r_sel.sample | r_sel.extest | r_sel.intest;
  // Concatenate TDI above the BSR so the shift also works for a single-cell chain.
  assign w_bsr_cat = {tap.TDI, r_bsr_sr};

  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      r_bypass   <= 1'b0;
      r_idcode   <= '0;
`ifdef JTAG_TAP_USERCODE_EN
      r_usercode <= '0;
`endif
      r_bsr_sr   <= '0;
      r_bsr_out  <= '0;
    end else begin
      case (r_state)
        S_CAPDR: begin
          if (r_sel.bypass)   r_bypass   <= 1'b0;
          if (r_sel.idcode)   r_idcode   <= IDCODE_VAL;
`ifdef JTAG_TAP_USERCODE_EN
          if (r_sel.usercode) r_usercode <= USERCODE_VAL;
`endif
          if (w_bsr_sel)      r_bsr_sr   <= tap.BSR_IN;
        end
        S_SHDR: begin
          if (r_sel.bypass)   r_bypass   <= tap.TDI;
          if (r_sel.idcode)   r_idcode   <= {tap.TDI, r_idcode[31:1]};
`ifdef JTAG_TAP_USERCODE_EN
          if (r_sel.usercode) r_usercode <= {tap.TDI, r_usercode[31:1]};
`endif
          if (w_bsr_sel)      r_bsr_sr   <= w_bsr_cat[BSR_LEN:1];
        end
        S_UPDR: begin
          if (w_bsr_sel)      r_bsr_out  <= r_bsr_sr;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_dr_lsb = r_bypass;
    if (r_sel.idcode)   w_dr_lsb = r_idcode[0];
`ifdef JTAG_TAP_USERCODE_EN
    if (r_sel.usercode) w_dr_lsb = r_usercode[0];
`endif
    if (w_bsr_sel)      w_dr_lsb = r_bsr_sr[0];
  end

  // TDO launches on the falling edge so the board samples it cleanly on the next rising edge.
  always_ff @(negedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      r_tdo    <= 1'b0;
      r_tdo_en <= 1'b0;
    end else if (r_state == S_SHDR) begin
      r_tdo    <= w_dr_lsb;
      r_tdo_en <= 1'b1;
    end else if (r_state == S_SHIR) begin
      r_tdo    <= r_ir_sr[0];
      r_tdo_en <= 1'b1;
    end else begin
      r_tdo    <= 1'b0;
      r_tdo_en <= 1'b0;
    end
  end

  assign tap.TDO        = r_tdo;
  assign tap.TDO_EN     = r_tdo_en;
  assign tap.STATE      = r_state;
  assign tap.TLR        = r_tlr;
  assign tap.IR_OUT     = r_ir_out;
  assign tap.BSR_OUT    = r_bsr_out;
  assign tap.BYPASS_SEL = r_sel.bypass;
  assign tap.IDCODE_SEL = r_sel.idcode;
  assign tap.SAMPLE_SEL = r_sel.sample;
  assign tap.EXTEST_SEL = r_sel.extest;
  assign tap.INTEST_SEL = r_sel.intest;

`ifdef JTAG_TAP_USERCODE_EN
  assign tap.USERCODE_SEL = r_sel.usercode;
`else
  logic w_unused_usercode;
  assign w_unused_usercode = ^{USERCODE_VAL, r_sel.usercode};
  assign tap.USERCODE_SEL  = 1'b0;
`endif

endmodule
